// File: rtl/ras_ckpt_if.sv
// Fetch-side bundle of the return address stack: call/return/branch controls
// in, top-of-stack prediction and checkpoint status out.
interface ras_ckpt_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] new_addr;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              branch_fetched;
  logic              branch_retired;
  logic              flush;
  logic              ckpt_full;
  logic              ckpt_overflow;

  modport master (
    output push, pop, new_addr, branch_fetched, branch_retired, flush,
    input  addr, addr_valid, ckpt_full, ckpt_overflow
  );

  modport slave (
    input  push, pop, new_addr, branch_fetched, branch_retired, flush,
    output addr, addr_valid, ckpt_full, ckpt_overflow
  );
endinterface

// File: rtl/ras_ckpt.sv
// Return address stack with a FIFO of speculative {tos, count} checkpoints;
// flush restores from the oldest outstanding checkpoint.
module ras_ckpt #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CKPT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  ras_ckpt_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam int unsigned CK_W  = $clog2(CKPT_DEPTH);
  localparam int unsigned OCC_W = $clog2(CKPT_DEPTH + 1);

  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
  } ckpt_t;

  logic [ADDR_W-1:0] mem [ENTRIES];
  ckpt_t             fifo [CKPT_DEPTH];

  logic [PTR_W-1:0]  tos, tos_nxt, base_tos;
  logic [CNT_W-1:0]  count, count_nxt, base_count;
  logic [CK_W-1:0]   head, tail;
  logic [OCC_W-1:0]  occ, occ_nxt;
  logic              overflow;

  logic              restore;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic              enq, deq, full;

  assign full    = (occ == OCC_W'(CKPT_DEPTH));
  assign restore = bus.flush && (occ != '0);

  // Stack next state is computed from the restored base, so a flush and a
  // call/return in the same cycle compose.
  always_comb begin
    base_tos   = restore ? fifo[head].tos   : tos;
    base_count = restore ? fifo[head].count : count;
    tos_nxt    = base_tos;
    count_nxt  = base_count;
    mem_we     = 1'b0;
    mem_waddr  = base_tos;
    if (bus.push && bus.pop) begin
      mem_we = 1'b1;
    end else if (bus.push) begin
      tos_nxt   = base_tos + PTR_W'(1);
      count_nxt = (base_count == CNT_W'(ENTRIES)) ? base_count : base_count + CNT_W'(1);
      mem_we    = 1'b1;
      mem_waddr = base_tos + PTR_W'(1);
    end else if (bus.pop) begin
      tos_nxt   = base_tos - PTR_W'(1);
      count_nxt = (base_count == '0) ? base_count : base_count - CNT_W'(1);
    end
  end

  // A fetch while full is only accepted when a retire frees the head slot.
  always_comb begin
    enq     = bus.branch_fetched && !bus.flush && (!full || bus.branch_retired);
    deq     = bus.branch_retired && !bus.flush && (occ != '0);
    occ_nxt = occ;
    if (enq && !deq) begin
      occ_nxt = occ + OCC_W'(1);
    end else if (deq && !enq) begin
      occ_nxt = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos      <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      tos   <= tos_nxt;
      count <= count_nxt;
      if (bus.flush) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (enq) tail <= tail + CK_W'(1);
        if (deq) head <= head + CK_W'(1);
        occ <= occ_nxt;
      end
      if (bus.branch_fetched && full && !bus.branch_retired && !bus.flush) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by count and occ.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= bus.new_addr;
    end
    if (!rst && enq) begin
      fifo[tail] <= '{tos: tos, count: count};
    end
  end

  assign bus.addr          = mem[tos];
  assign bus.addr_valid    = (count != '0);
  assign bus.ckpt_full     = full;
  assign bus.ckpt_overflow = overflow;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: stack ordering, wrap at depth, checkpoint
// restore on flush, checkpoint FIFO full/overflow and reset.
module tb_ras_ckpt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ras_ckpt_if #(.ADDR_W(32)) bus ();

  ras_ckpt #(.ENTRIES(8), .ADDR_W(32), .CKPT_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push           = 1'b0;
    bus.pop            = 1'b0;
    bus.new_addr       = '0;
    bus.branch_fetched = 1'b0;
    bus.branch_retired = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] a);
    bus.push = 1'b1; bus.new_addr = a; step(); idle();
  endtask

  task automatic do_pop();
    bus.pop = 1'b1; step(); idle();
  endtask

  task automatic do_fetch(input logic retire);
    bus.branch_fetched = 1'b1; bus.branch_retired = retire; step(); idle();
  endtask

  task automatic do_retire();
    bus.branch_retired = 1'b1; step(); idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    idle();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_full", 32'(bus.ckpt_full), 32'd0);
    chk("rst_ovf", 32'(bus.ckpt_overflow), 32'd0);

    // LIFO order and pop past empty
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("lifo_top", bus.addr, 32'h300);
    chk("lifo_valid", 32'(bus.addr_valid), 32'd1);
    do_pop(); chk("lifo_pop1", bus.addr, 32'h200);
    do_pop(); chk("lifo_pop2", bus.addr, 32'h100);
    chk("lifo_pop2_valid", 32'(bus.addr_valid), 32'd1);
    do_pop(); chk("lifo_pop3_valid", 32'(bus.addr_valid), 32'd0);
    do_pop(); chk("lifo_pop4_valid", 32'(bus.addr_valid), 32'd0);

    // Nine pushes into eight entries: oldest overwritten, count saturates
    do_reset();
    for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
    chk("wrap_top", bus.addr, 32'h90);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap_before_pop%0d", k), bus.addr, 32'h90 - 32'(k * 16));
      chk($sformatf("wrap_valid%0d", k), 32'(bus.addr_valid), 32'd1);
      do_pop();
    end
    chk("wrap_empty", 32'(bus.addr_valid), 32'd0);

    // Flush restores the checkpoint taken at tos=2, count=2
    do_reset();
    do_push(32'hA); do_push(32'hB);
    do_fetch(1'b0);
    do_push(32'hC);
    chk("ck_push_c", bus.addr, 32'hC);
    do_pop(); do_pop();
    chk("ck_spec_top", bus.addr, 32'hA);
    bus.flush = 1'b1; step(); idle();
    chk("ck_restore_addr", bus.addr, 32'hB);
    chk("ck_restore_full", 32'(bus.ckpt_full), 32'd0);
    do_pop(); chk("ck_restore_pop1", bus.addr, 32'hA);
    chk("ck_restore_pop1_valid", 32'(bus.addr_valid), 32'd1);
    do_pop(); chk("ck_restore_pop2_valid", 32'(bus.addr_valid), 32'd0);

    // Retire oldest, then flush with a push: restore to tos=3 then push
    do_reset();
    do_push(32'h1);
    do_fetch(1'b0);
    do_push(32'h2); do_push(32'h3);
    do_fetch(1'b0);
    do_push(32'h4); do_push(32'h5);
    do_retire();
    bus.flush = 1'b1; bus.push = 1'b1; bus.new_addr = 32'hEE; step(); idle();
    chk("fp_addr", bus.addr, 32'hEE);
    do_pop(); chk("fp_pop", bus.addr, 32'h3);
    bus.flush = 1'b1; step(); idle();
    chk("fp_empty_flush", bus.addr, 32'h3);
    do_pop(); do_pop();
    chk("fp_count_low", bus.addr, 32'h1);
    chk("fp_count_low_valid", 32'(bus.addr_valid), 32'd1);
    do_pop(); chk("fp_count_empty", 32'(bus.addr_valid), 32'd0);

    // Checkpoint FIFO full and overflow
    do_reset();
    do_retire();
    for (int i = 0; i < 3; i++) do_fetch(1'b0);
    chk("cf_three", 32'(bus.ckpt_full), 32'd0);
    do_fetch(1'b0);
    chk("cf_four", 32'(bus.ckpt_full), 32'd1);
    do_fetch(1'b1);
    chk("cf_swap_full", 32'(bus.ckpt_full), 32'd1);
    chk("cf_swap_ovf", 32'(bus.ckpt_overflow), 32'd0);
    do_fetch(1'b0);
    chk("cf_ovf", 32'(bus.ckpt_overflow), 32'd1);
    chk("cf_ovf_full", 32'(bus.ckpt_full), 32'd1);
    do_retire();
    chk("cf_after_retire", 32'(bus.ckpt_full), 32'd0);
    chk("cf_ovf_sticky", 32'(bus.ckpt_overflow), 32'd1);
    bus.flush = 1'b1; bus.branch_fetched = 1'b1; step(); idle();
    chk("cf_flush_clear", 32'(bus.ckpt_full), 32'd0);
    for (int i = 0; i < 3; i++) do_fetch(1'b0);
    chk("cf_refill3", 32'(bus.ckpt_full), 32'd0);

    // Replace top with simultaneous push and pop, then mid-run reset
    do_push(32'h30); do_push(32'h40);
    bus.push = 1'b1; bus.pop = 1'b1; bus.new_addr = 32'h44; step(); idle();
    chk("pp_addr", bus.addr, 32'h44);
    do_pop(); chk("pp_pop", bus.addr, 32'h30);
    chk("pp_valid", 32'(bus.addr_valid), 32'd1);
    do_fetch(1'b0);
    chk("pp_full", 32'(bus.ckpt_full), 32'd1);
    rst = 1'b1; bus.push = 1'b1; bus.new_addr = 32'h55; bus.branch_fetched = 1'b1;
    step(); idle(); rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ckpt_overflow), 32'd0);
    chk("mid_rst_full", 32'(bus.ckpt_full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
